// File: rtl/rtc_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_stopwatch_ctrl
//   Run/stop/lap/reset sequencer for the stopwatch BCD counter chain.
//   Two raw push-buttons are synchronised (2 flops), debounced and turned
//   into single-cycle press pulses. A 4-state Moore FSM then drives the
//   counter init/enable controls and the display latch.
//
//   Optional feature macro: RTC_LAP_EN. When defined, the LAP state is
//   reachable from RUN via the lap/reset button. When undefined, lap/reset
//   only returns STOP to IDLE, and o_state never reads 2'b10.
//
// Parameters
//   DEBOUNCE_CNT  consecutive samples of a new synced level needed (>= 1)
//
// Ports
//   i_sclk        system clock, rising edge
//   i_reset_n     synchronous active-low reset
//   i_startstop   raw start/stop button (async, active-high)
//   i_lapreset    raw lap/reset button (async, active-high)
//   i_count_max   counter at terminal value, synchronous to i_sclk
//   o_countinit   1 = clear counter
//   o_countenb    1 = counter advances
//   o_latchcount  1 = display follows counter, 0 = frozen
//   o_state       00 IDLE, 01 RUN, 10 LAP, 11 STOP
//   o_overflow    sticky terminal-count flag, cleared on entering IDLE
// ---------------------------------------------------------------------------
module rtc_stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       i_sclk,
  input  logic       i_reset_n,
  input  logic       i_startstop,
  input  logic       i_lapreset,
  input  logic       i_count_max,
  output logic       o_countinit,
  output logic       o_countenb,
  output logic       o_latchcount,
  output logic [1:0] o_state,
  output logic       o_overflow
);

  // Counter only needs to hold 0..DEBOUNCE_CNT-1; the flip happens on the
  // sample that would take it to DEBOUNCE_CNT.
  localparam int unsigned CntW = (DEBOUNCE_CNT < 2) ? 1 : $clog2(DEBOUNCE_CNT);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StLap  = 2'b10,
    StStop = 2'b11
  } state_e;

  // Bit 0 = start/stop, bit 1 = lap/reset.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      deb_q;
  logic [1:0]      deb_prev_q;
  logic [1:0]      pulse_q;
  logic [CntW-1:0] cnt_q [2];

  logic   ss_pulse;
  logic   lr_pulse;
  state_e state_q, state_d;
  logic   ovf_q, ovf_d;
  logic   countinit_q, countenb_q, latchcount_q;

  assign btn_raw  = {i_lapreset, i_startstop};
  assign ss_pulse = pulse_q[0];
  assign lr_pulse = pulse_q[1];

  // ---------------------------------------------------------------------
  // Synchroniser, debounce and press-pulse generation
  // ---------------------------------------------------------------------
  always_ff @(posedge i_sclk) begin
    if (!i_reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      // Registered rising-edge detect keeps the FSM free of comb input paths.
      pulse_q    <= deb_q & ~deb_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            deb_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CntW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (ss_pulse) state_d = StRun;
      end
      StRun: begin
        // Terminal count outranks both buttons.
        if (i_count_max) begin
          state_d = StStop;
          ovf_d   = 1'b1;
        end else if (ss_pulse) begin
          state_d = StStop;
        end
`ifdef RTC_LAP_EN
        else if (lr_pulse) begin
          state_d = StLap;
        end
`endif
      end
      StLap: begin
`ifdef RTC_LAP_EN
        if (i_count_max) begin
          state_d = StStop;
          ovf_d   = 1'b1;
        end else if (ss_pulse) begin
          state_d = StStop;
        end else if (lr_pulse) begin
          state_d = StRun;
        end
`else
        // Unreachable without lap support; recover to a safe state.
        state_d = StIdle;
`endif
      end
      StStop: begin
        // A start/stop press always consumes a coincident lap/reset press,
        // even when an overflow blocks the resume.
        if (ss_pulse) begin
          if (!ovf_q) state_d = StRun;
        end else if (lr_pulse) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle) ovf_d = 1'b0;
  end

  // {countinit, countenb, latchcount} for a given state.
  function automatic logic [2:0] decode_outputs(input state_e st);
    case (st)
      StIdle:  decode_outputs = 3'b101;
      StRun:   decode_outputs = 3'b011;
      StLap:   decode_outputs = 3'b010;
      StStop:  decode_outputs = 3'b001;
      default: decode_outputs = 3'b101;
    endcase
  endfunction

  // State and outputs registered together so outputs are glitch-free.
  always_ff @(posedge i_sclk) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      ovf_q        <= 1'b0;
      countinit_q  <= 1'b1;
      countenb_q   <= 1'b0;
      latchcount_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      {countinit_q, countenb_q, latchcount_q} <= decode_outputs(state_d);
    end
  end

  assign o_countinit  = countinit_q;
  assign o_countenb   = countenb_q;
  assign o_latchcount = latchcount_q;
  assign o_state      = state_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_rtc_stopwatch_ctrl.sv
// Self-checking bench for rtc_stopwatch_ctrl (DEBOUNCE_CNT = 4).
// Expected output vectors {state, countinit, countenb, latchcount, overflow}
// are queued when stimulus is applied and compared when the DUT responds.
module tb_rtc_stopwatch_ctrl;

  localparam int unsigned Deb = 4;

  // Expected output vectors: {state[1:0], countinit, countenb, latchcount, overflow}
  localparam logic [5:0] ExpIdle    = 6'b00_1_0_1_0;
  localparam logic [5:0] ExpRun     = 6'b01_0_1_1_0;
  localparam logic [5:0] ExpLap     = 6'b10_0_1_0_0;
  localparam logic [5:0] ExpStop    = 6'b11_0_0_1_0;
  localparam logic [5:0] ExpStopOvf = 6'b11_0_0_1_1;

  logic       clk;
  logic       rst_n;
  logic       ss;
  logic       lr;
  logic       cmax;
  logic       countinit;
  logic       countenb;
  logic       latchcount;
  logic [1:0] state;
  logic       overflow;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_fail;

  rtc_stopwatch_ctrl #(
    .DEBOUNCE_CNT(Deb)
  ) dut (
    .i_sclk      (clk),
    .i_reset_n   (rst_n),
    .i_startstop (ss),
    .i_lapreset  (lr),
    .i_count_max (cmax),
    .o_countinit (countinit),
    .o_countenb  (countenb),
    .o_latchcount(latchcount),
    .o_state     (state),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {state, countinit, countenb, latchcount, overflow};
  endfunction

  // Wait n rising edges, then step 1 time unit clear of the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press for 8 cycles (long enough for the 7-edge latency), release, settle.
  task automatic press(input logic s, input logic l);
    ss = s;
    lr = l;
    tick(Deb + 4);
    ss = 1'b0;
    lr = 1'b0;
    tick(Deb + 6);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    sb_q.push_back('{"reset", ExpIdle});
    tick(2);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_bounce();
    exp_t e;
    sb_q.push_back('{"bounce_rejected", ExpIdle});
    ss = 1'b1; tick(3);
    ss = 1'b0; tick(3);
    ss = 1'b1; tick(3);
    ss = 1'b0; tick(12);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    // Terminal count is ignored in IDLE.
    sb_q.push_back('{"cmax_in_idle", ExpIdle});
    cmax = 1'b1; tick(1);
    cmax = 1'b0; tick(1);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
  endtask

  task automatic test_startstop();
    exp_t e;
    sb_q.push_back('{"ss_latency_edge6", ExpIdle});
    sb_q.push_back('{"ss_latency_edge7", ExpRun});
    sb_q.push_back('{"ss_to_stop", ExpStop});
    sb_q.push_back('{"ss_resume", ExpRun});
    ss = 1'b1;
    tick(Deb + 3);  // just after edge 6 (edge 0 samples high)
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    tick(1);        // just after edge 7
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    tick(2);
    ss = 1'b0;
    tick(12);
    press(1'b1, 1'b0);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    press(1'b1, 1'b0);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
  endtask

  task automatic test_lap();
    exp_t e;
`ifdef RTC_LAP_EN
    sb_q.push_back('{"lap_enter", ExpLap});
`else
    sb_q.push_back('{"lap_ignored", ExpRun});
`endif
    sb_q.push_back('{"lap_exit", ExpRun});
    for (int k = 0; k < 2; k++) begin
      press(1'b0, 1'b1);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs() !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    sb_q.push_back('{"ovf_stop", ExpStopOvf});
    sb_q.push_back('{"ovf_ss_ignored", ExpStopOvf});
    sb_q.push_back('{"ovf_lr_idle", ExpIdle});
    cmax = 1'b1;
    tick(1);
    cmax = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    for (int k = 0; k < 2; k++) begin
      press(k == 0, k == 1);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs() !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    sb_q.push_back('{"simul_pre_run", ExpRun});
    sb_q.push_back('{"simul_ss_wins", ExpStop});
    press(1'b1, 1'b0);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    press(1'b1, 1'b1);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    sb_q.push_back('{"midrst_pre_run", ExpRun});
    sb_q.push_back('{"midrst_idle", ExpIdle});
    press(1'b1, 1'b0);  // STOP -> RUN
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    rst_n = 1'b0;
    tick(1);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_held_through_reset();
    exp_t e;
    sb_q.push_back('{"held_edge6", ExpIdle});
    sb_q.push_back('{"held_edge7", ExpRun});
    sb_q.push_back('{"held_single", ExpRun});
    ss    = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(Deb + 3);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    tick(1);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    // Still held: no second press may follow.
    tick(20);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    ss = 1'b0;
    tick(12);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    ss     = 1'b0;
    lr     = 1'b0;
    cmax   = 1'b0;
    tick(1);
    test_reset();
    test_bounce();
    test_startstop();      // ends in RUN
    test_lap();            // ends in RUN
    test_overflow();       // ends in IDLE
    test_simultaneous();   // ends in STOP
    test_reset_mid_run();  // ends in IDLE
    test_held_through_reset();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
